// File: rtl/id_stage_fwdn.sv
// id_stage_fwdn: RV32 decode stage between IF and EX.
//   Decodes the held instruction, reads the external regfile and overrides the
//   read data with the highest-priority matching bypass source. It resolves
//   branches and jumps locally when BRANCH_IN_ID is set. It also supports flush,
//   marks illegal opcodes, and keeps a saturating count of hazard-stall cycles.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   if_valid, if_bus         IF handshake, {inst, pc}
//   id_allowin               ID can take if_bus this cycle
//   ex_allowin               EX can take id_to_ex_bus this cycle
//   id_to_ex_valid/_bus      decoded instruction towards EX (162 bits)
//   fwd_bus                  NUM_FWD x {rdy, wr, addr[4:0], data[31:0]}, entry 0 youngest
//   rf_raddr1/2, rf_rdata1/2 asynchronous regfile read ports
//   flush                    squash the instruction held in ID
//   br_bus                   {redirect_wen, target}
//   illegal                  pulse when an illegal instruction fires to EX
//   stall_cnt                saturating hazard-stall cycle count
module id_stage_fwdn #(
    parameter int unsigned NUM_FWD      = 3,
    parameter int unsigned BRANCH_IN_ID = 1,
    parameter int unsigned BR_FWD       = 0,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid,
    input  logic [63:0]            if_bus,
    output logic                   id_allowin,
    input  logic                   ex_allowin,
    output logic                   id_to_ex_valid,
    output logic [161:0]           id_to_ex_bus,
    input  logic [NUM_FWD*39-1:0]  fwd_bus,
    output logic [4:0]             rf_raddr1,
    output logic [4:0]             rf_raddr2,
    input  logic [31:0]            rf_rdata1,
    input  logic [31:0]            rf_rdata2,
    input  logic                   flush,
    output logic [32:0]            br_bus,
    output logic                   illegal,
    output logic [CNT_W-1:0]       stall_cnt
);

    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;

    // State
    logic             valid_q, valid_d;
    logic [31:0]      inst_q, pc_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load;

    // Decode
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic        is_r, is_i, is_s, is_b, is_u, is_j, is_jalr, is_illegal;
    logic        wb_wen;
    logic [31:0] imm;

    // Forwarding / hazard
    logic        hit1, hit2, rdy1, rdy2;
    logic [31:0] fdat1, fdat2, src1, src2;
    logic        use1, use2, haz1, haz2, id_ready, fire;

    // Branch
    logic        taken, redirect;
    logic [31:0] target;

    assign opcode = inst_q[6:0];
    assign rd     = inst_q[11:7];
    assign funct3 = inst_q[14:12];
    assign rs1    = inst_q[19:15];
    assign rs2    = inst_q[24:20];
    assign funct7 = inst_q[31:25];

    assign is_r       = (opcode == OpReg);
    assign is_i       = (opcode == OpImm) | (opcode == OpJalr) | (opcode == OpLoad);
    assign is_s       = (opcode == OpStore);
    assign is_b       = (opcode == OpBranch);
    assign is_u       = (opcode == OpLui) | (opcode == OpAuipc);
    assign is_j       = (opcode == OpJal);
    assign is_jalr    = (opcode == OpJalr);
    assign is_illegal = ~(is_r | is_i | is_s | is_b | is_u | is_j);
    assign wb_wen     = is_j | is_i | is_r | is_u;

    always_comb begin
        imm = 32'd0;
        if (is_i) begin
            imm = {{20{inst_q[31]}}, inst_q[31:20]};
        end else if (is_s) begin
            imm = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
        end else if (is_b) begin
            imm = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
        end else if (is_u) begin
            imm = {inst_q[31:12], 12'd0};
        end else if (is_j) begin
            imm = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21],
                   1'b0};
        end
    end

    assign rf_raddr1 = rs1;
    assign rf_raddr2 = rs2;

    // First matching entry in index order wins; x0 never matches so it reads 0
    // from the regfile.
    always_comb begin
        hit1  = 1'b0;
        rdy1  = 1'b0;
        fdat1 = 32'd0;
        hit2  = 1'b0;
        rdy2  = 1'b0;
        fdat2 = 32'd0;
        for (int i = 0; i < int'(NUM_FWD); i++) begin
            if (!hit1 && rs1 != 5'd0 && fwd_bus[39*i+37] && fwd_bus[39*i+32 +: 5] == rs1) begin
                hit1  = 1'b1;
                rdy1  = fwd_bus[39*i+38];
                fdat1 = fwd_bus[39*i +: 32];
            end
            if (!hit2 && rs2 != 5'd0 && fwd_bus[39*i+37] && fwd_bus[39*i+32 +: 5] == rs2) begin
                hit2  = 1'b1;
                rdy2  = fwd_bus[39*i+38];
                fdat2 = fwd_bus[39*i +: 32];
            end
        end
    end

    assign src1 = hit1 ? fdat1 : rf_rdata1;
    assign src2 = hit2 ? fdat2 : rf_rdata2;

    // Only operands the instruction actually reads can cause a stall.
    assign use1     = ~(is_u | is_j);
    assign use2     = is_r | is_s | is_b;
    assign haz1     = use1 & hit1 & (~rdy1 | (is_b & (BR_FWD == 0)));
    assign haz2     = use2 & hit2 & (~rdy2 | (is_b & (BR_FWD == 0)));
    assign id_ready = ~(haz1 | haz2);

    assign id_allowin     = ~valid_q | (id_ready & ex_allowin);
    assign id_to_ex_valid = valid_q & id_ready & ~flush;
    assign fire           = id_to_ex_valid & ex_allowin;

    always_comb begin
        case (funct3)
            3'b000:  taken = (src1 == src2);
            3'b001:  taken = (src1 != src2);
            3'b100:  taken = ($signed(src1) < $signed(src2));
            3'b101:  taken = ($signed(src1) >= $signed(src2));
            3'b110:  taken = (src1 < src2);
            3'b111:  taken = (src1 >= src2);
            default: taken = 1'b0;
        endcase
    end

    assign target   = is_jalr ? ((src1 + imm) & ~32'd1) : (pc_q + imm);
    assign redirect = (BRANCH_IN_ID != 0) & fire & ((is_b & taken) | is_j | is_jalr);
    assign br_bus   = redirect ? {1'b1, target} : 33'd0;

    assign illegal   = fire & is_illegal;
    assign stall_cnt = cnt_q;

    assign id_to_ex_bus = {rs1, rs2, rd, src1, src2, funct3, funct7, opcode,
                           wb_wen, is_illegal, imm, pc_q};

    // Next state
    assign load = if_valid & id_allowin & ~flush;

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (id_allowin) begin
            valid_d = if_valid;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (valid_q && !id_ready && !flush && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Payload has no reset: it is only observed while valid_q is set.
    always_ff @(posedge clk) begin
        if (load) begin
            inst_q <= if_bus[63:32];
            pc_q   <= if_bus[31:0];
        end
    end

endmodule

// File: tb/tb_id_stage_fwdn.sv
module tb_id_stage_fwdn;

    localparam int NF   = 3;
    localparam int BIID = 1;
    localparam int BRF  = 0;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, if_valid, ex_allowin, flush;
    logic [63:0]    if_bus;
    logic           id_allowin, id_to_ex_valid, illegal;
    logic [161:0]   id_to_ex_bus;
    logic [NF*39-1:0] fwd_bus;
    logic [4:0]     rf_raddr1, rf_raddr2;
    logic [31:0]    rf_rdata1, rf_rdata2;
    logic [32:0]    br_bus;
    logic [CW-1:0]  stall_cnt;

    logic           f_rdy [NF];
    logic           f_wr  [NF];
    logic [4:0]     f_addr[NF];
    logic [31:0]    f_data[NF];
    logic [31:0]    rf    [32];

    for (genvar g = 0; g < NF; g++) begin : g_fwd
        assign fwd_bus[39*g +: 39] = {f_rdy[g], f_wr[g], f_addr[g], f_data[g]};
    end

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    id_stage_fwdn #(
        .NUM_FWD     (NF),
        .BRANCH_IN_ID(BIID),
        .BR_FWD      (BRF),
        .CNT_W       (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_valid      (if_valid),
        .if_bus        (if_bus),
        .id_allowin    (id_allowin),
        .ex_allowin    (ex_allowin),
        .id_to_ex_valid(id_to_ex_valid),
        .id_to_ex_bus  (id_to_ex_bus),
        .fwd_bus       (fwd_bus),
        .rf_raddr1     (rf_raddr1),
        .rf_raddr2     (rf_raddr2),
        .rf_rdata1     (rf_rdata1),
        .rf_rdata2     (rf_rdata2),
        .flush         (flush),
        .br_bus        (br_bus),
        .illegal       (illegal),
        .stall_cnt     (stall_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit          m_valid = 1'b0;
    logic [31:0] m_inst  = 32'd0;
    logic [31:0] m_pc    = 32'd0;
    int          m_cnt   = 0;
    bit          e_ready, e_allowin;

    task automatic check_eq(input string tag, input logic [161:0] got, input logic [161:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic void opnd(input logic [4:0] rs, output bit hit, output bit rdy,
                                 output logic [31:0] val);
        hit = 1'b0;
        rdy = 1'b1;
        val = rf[rs];
        for (int i = 0; i < NF; i++) begin
            if (!hit && rs != 5'd0 && f_wr[i] && f_addr[i] == rs) begin
                hit = 1'b1;
                rdy = f_rdy[i];
                val = f_data[i];
            end
        end
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input logic [4:0] r1, input logic [4:0] r2,
                                          input logic [2:0] f3);
        logic [12:0] b;
        b = 13'(imm);
        return {b[12], b[10:5], r2, r1, f3, b[4:1], b[11], 7'b1100011};
    endfunction

    task automatic clr_fwd();
        for (int i = 0; i < NF; i++) begin
            f_rdy[i]  = 1'b1;
            f_wr[i]   = 1'b0;
            f_addr[i] = 5'd0;
            f_data[i] = 32'd0;
        end
    endtask

    // Apply inputs (called just after a falling edge), then compare every output
    // against the model.
    task automatic drive(input bit r, input bit iv, input logic [31:0] inst, input logic [31:0] pc,
                         input bit exa, input bit fl, input bit chk);
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic [4:0]  s1a, s2a, rda;
        bit          is_r, is_i, is_s, is_b, is_u, is_j, is_jr, ill, wb;
        bit          h1, h2, r1, r2, haz, ev, fire, tk, redir;
        logic [31:0] s1, s2, imm, tgt;
        logic [32:0] exp_br;
        rst = r; if_valid = iv; if_bus = {inst, pc}; ex_allowin = exa; flush = fl;
        #1;
        opc = m_inst[6:0];  rda = m_inst[11:7];  f3 = m_inst[14:12];
        s1a = m_inst[19:15]; s2a = m_inst[24:20]; f7 = m_inst[31:25];
        is_r  = opc == 7'h33;
        is_jr = opc == 7'h67;
        is_i  = opc == 7'h13 || is_jr || opc == 7'h03;
        is_s  = opc == 7'h23;
        is_b  = opc == 7'h63;
        is_u  = opc == 7'h37 || opc == 7'h17;
        is_j  = opc == 7'h6F;
        ill   = !(is_r || is_i || is_s || is_b || is_u || is_j);
        wb    = is_r || is_i || is_u || is_j;
        if (is_i)      imm = 32'($signed(m_inst[31:20]));
        else if (is_s) imm = 32'($signed({m_inst[31:25], m_inst[11:7]}));
        else if (is_b) imm = 32'($signed({m_inst[31], m_inst[7], m_inst[30:25], m_inst[11:8], 1'b0}));
        else if (is_u) imm = m_inst & 32'hFFFF_F000;
        else if (is_j) imm = 32'($signed({m_inst[31], m_inst[19:12], m_inst[20], m_inst[30:21], 1'b0}));
        else           imm = 32'd0;
        opnd(s1a, h1, r1, s1);
        opnd(s2a, h2, r2, s2);
        haz = 1'b0;
        if (!(is_u || is_j) && h1 && (!r1 || (is_b && BRF == 0))) haz = 1'b1;
        if ((is_r || is_s || is_b) && h2 && (!r2 || (is_b && BRF == 0))) haz = 1'b1;
        e_ready   = !haz;
        e_allowin = !m_valid || (e_ready && exa);
        ev        = m_valid && e_ready && !fl;
        fire      = ev && exa;
        case (f3)
            3'd0: tk = s1 == s2;
            3'd1: tk = s1 != s2;
            3'd4: tk = $signed(s1) < $signed(s2);
            3'd5: tk = $signed(s1) >= $signed(s2);
            3'd6: tk = s1 < s2;
            3'd7: tk = s1 >= s2;
            default: tk = 1'b0;
        endcase
        tgt    = is_jr ? ((s1 + imm) & 32'hFFFF_FFFE) : (m_pc + imm);
        redir  = BIID != 0 && fire && ((is_b && tk) || is_j || is_jr);
        exp_br = redir ? {1'b1, tgt} : 33'd0;
        if (chk) begin
            check_eq("id_allowin", 162'(id_allowin), 162'(e_allowin));
            check_eq("id_to_ex_valid", 162'(id_to_ex_valid), 162'(ev));
            check_eq("br_bus", 162'(br_bus), 162'(exp_br));
            check_eq("illegal", 162'(illegal), 162'(fire && ill));
            check_eq("stall_cnt", 162'(stall_cnt), 162'(m_cnt));
            if (m_valid) begin
                check_eq("rf_raddr1", 162'(rf_raddr1), 162'(s1a));
                check_eq("rf_raddr2", 162'(rf_raddr2), 162'(s2a));
            end
            if (ev) begin
                check_eq("id_to_ex_bus", id_to_ex_bus,
                         {s1a, s2a, rda, s1, s2, f3, f7, opc, wb, ill, imm, m_pc});
            end
        end
    endtask

    // Advance one clock: update the model at the rising edge, return at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            m_valid = 1'b0;
            m_cnt   = 0;
        end else begin
            if (m_valid && !e_ready && !flush && m_cnt < CMAX) m_cnt++;
            if (if_valid && e_allowin && !flush) begin
                m_inst = if_bus[63:32];
                m_pc   = if_bus[31:0];
            end
            if (flush) m_valid = 1'b0;
            else if (e_allowin) m_valid = if_valid;
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [6:0]  ops[12];
        ops = '{7'h13, 7'h37, 7'h17, 7'h33, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h7F, 7'h0F, 7'h73};
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 11)];
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    function automatic logic [31:0] rand_data();
        return ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 2));
    endfunction

    localparam logic [31:0] AddiX1 = {12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011};
    localparam logic [31:0] AddX4  = {7'd0, 5'd3, 5'd3, 3'b000, 5'd4, 7'b0110011};
    localparam logic [31:0] JalrX1 = {12'd3, 5'd7, 3'b000, 5'd1, 7'b1100111};

    initial begin
        rf[0] = 32'd0;
        for (int i = 1; i < 32; i++) rf[i] = rand_data();
        clr_fwd();
        rst = 1'b0; if_valid = 1'b0; if_bus = 64'd0; ex_allowin = 1'b1; flush = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        tick();

        // Reset state
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        check_eq("rst_allowin", 162'(id_allowin), 162'(1'b1));
        check_eq("rst_valid", 162'(id_to_ex_valid), 162'(1'b0));
        check_eq("rst_br", 162'(br_bus), 162'd0);
        check_eq("rst_cnt", 162'(stall_cnt), 162'd0);

        // ADDI x1,x0,5 at 0x100
        drive(1'b1, 1'b1, AddiX1, 32'h100, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        check_eq("addi_valid", 162'(id_to_ex_valid), 162'(1'b1));
        check_eq("addi_imm", 162'(id_to_ex_bus[63:32]), 162'(32'd5));
        check_eq("addi_rd", 162'(id_to_ex_bus[151:147]), 162'(5'd1));
        check_eq("addi_src1", 162'(id_to_ex_bus[146:115]), 162'd0);
        check_eq("addi_pc", 162'(id_to_ex_bus[31:0]), 162'(32'h100));
        tick();

        // Forward priority, then a 4-cycle not-ready stall
        f_rdy[0] = 1'b1; f_wr[0] = 1'b1; f_addr[0] = 5'd3; f_data[0] = 32'hAAAA;
        f_rdy[2] = 1'b1; f_wr[2] = 1'b1; f_addr[2] = 5'd3; f_data[2] = 32'hBBBB;
        drive(1'b1, 1'b1, AddX4, 32'h104, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        check_eq("prio_src1", 162'(id_to_ex_bus[146:115]), 162'(32'hAAAA));
        check_eq("prio_src2", 162'(id_to_ex_bus[114:83]), 162'(32'hAAAA));
        tick();
        f_rdy[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
            check_eq("stall_valid", 162'(id_to_ex_valid), 162'(1'b0));
            tick();
        end
        f_rdy[0] = 1'b1;
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        check_eq("stall_cnt4", 162'(stall_cnt), 162'(4'd4));
        check_eq("stall_fire", 162'(id_to_ex_valid), 162'(1'b1));
        check_eq("stall_src1", 162'(id_to_ex_bus[146:115]), 162'(32'hAAAA));
        tick();

        // BLT / BLTU
        clr_fwd();
        rf[5] = 32'hFFFF_FFFF; rf[6] = 32'd1;
        drive(1'b1, 1'b1, enc_b(-8, 5'd5, 5'd6, 3'b100), 32'h200, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        check_eq("blt_br", 162'(br_bus), 162'({1'b1, 32'h1F8}));
        tick();
        drive(1'b1, 1'b1, enc_b(-8, 5'd5, 5'd6, 3'b110), 32'h200, 1'b1, 1'b0, 1'b1);
        check_eq("blt_pulse", 162'(br_bus), 162'd0);
        tick();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        check_eq("bltu_wen", 162'(br_bus[32]), 162'(1'b0));
        tick();

        // JALR with forwarded base, then BEQ stalling on a ready forward
        f_rdy[0] = 1'b1; f_wr[0] = 1'b1; f_addr[0] = 5'd7; f_data[0] = 32'h1000;
        drive(1'b1, 1'b1, JalrX1, 32'h300, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b1, enc_b(8, 5'd7, 5'd0, 3'b000), 32'h304, 1'b1, 1'b0, 1'b1);
        check_eq("jalr_br", 162'(br_bus), 162'({1'b1, 32'h1002}));
        tick();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        check_eq("beq_stall", 162'(id_to_ex_valid), 162'(1'b0));
        tick();
        clr_fwd();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        check_eq("beq_go", 162'(id_to_ex_valid), 162'(1'b1));
        tick();

        // Flush a taken branch, dropping a simultaneous new instruction
        drive(1'b1, 1'b1, enc_b(-8, 5'd5, 5'd6, 3'b100), 32'h200, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b1, AddiX1, 32'h400, 1'b1, 1'b1, 1'b1);
        check_eq("flush_valid", 162'(id_to_ex_valid), 162'(1'b0));
        check_eq("flush_br", 162'(br_bus), 162'd0);
        tick();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        check_eq("flush_drop", 162'(id_to_ex_valid), 162'(1'b0));
        tick();

        // Illegal opcode
        drive(1'b1, 1'b1, 32'h0000_007F, 32'h500, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        check_eq("ill_pin", 162'(illegal), 162'(1'b1));
        check_eq("ill_bit", 162'(id_to_ex_bus[65:64]), 162'(2'b01));
        tick();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        check_eq("ill_pulse", 162'(illegal), 162'(1'b0));
        tick();

        // Reset in the middle of a stall
        f_rdy[0] = 1'b0; f_wr[0] = 1'b1; f_addr[0] = 5'd3; f_data[0] = 32'h1;
        drive(1'b1, 1'b1, AddX4, 32'h600, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        check_eq("rst2_valid", 162'(id_to_ex_valid), 162'(1'b0));
        check_eq("rst2_allowin", 162'(id_allowin), 162'(1'b1));
        check_eq("rst2_cnt", 162'(stall_cnt), 162'd0);
        tick();

        // Randomized traffic
        for (int i = 1; i < 32; i++) rf[i] = rand_data();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NF; i++) begin
                f_rdy[i]  = $urandom_range(0, 3) != 0;
                f_wr[i]   = $urandom_range(0, 1) != 0;
                f_addr[i] = 5'($urandom_range(0, 7));
                f_data[i] = rand_data();
            end
            drive($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7, rand_inst(),
                  $urandom & 32'hFFFF_FFFC, $urandom_range(0, 9) < 8,
                  $urandom_range(0, 19) == 0, 1'b1);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
